// File: rtl/endp_packet_injector_pkg.sv
// Shared configuration, flit layout and FSM state type for the endpoint packet injector.
package endp_packet_injector_pkg;

   localparam int unsigned V           = 2;
   localparam int unsigned B           = 4;
   localparam int unsigned Fpay        = 32;
   localparam int unsigned DAw         = 8;
   localparam int unsigned MAX_PCK_SIZ = 16;

   localparam int unsigned PLw = $clog2(MAX_PCK_SIZ + 1);
   localparam int unsigned Fw  = 2 + V + Fpay;
   localparam int unsigned Cw  = $clog2(B + 1);
   localparam int unsigned VW  = (V > 1) ? $clog2(V) : 1;

   // flit = {hdr, tail, vc_onehot[V-1:0], payload}
   localparam int unsigned HDR_BIT  = Fw - 1;
   localparam int unsigned TAIL_BIT = Fw - 2;
   localparam int unsigned VC_LSB   = Fpay;

   // head payload = {zeros, size, src, dest}
   localparam int unsigned HEAD_DEST_LSB = 0;
   localparam int unsigned HEAD_SRC_LSB  = DAw;
   localparam int unsigned HEAD_SIZE_LSB = 2 * DAw;

   typedef enum logic [1:0] {IDLE, HEAD, BODY} inj_state_e;

   // Assemble a flit from its fields.
   function automatic logic [Fw-1:0] pack_flit(input logic hdr, input logic tail,
                                               input logic [V-1:0] vc_oh,
                                               input logic [Fpay-1:0] pay);
      logic [Fw-1:0] f;
      f                 = '0;
      f[HDR_BIT]        = hdr;
      f[TAIL_BIT]       = tail;
      f[VC_LSB +: V]    = vc_oh;
      f[Fpay-1:0]       = pay;
      return f;
   endfunction

   // Build the head-flit payload; unused upper bits stay zero.
   function automatic logic [Fpay-1:0] head_payload(input logic [PLw-1:0] size,
                                                    input logic [DAw-1:0] src,
                                                    input logic [DAw-1:0] dest);
      logic [Fpay-1:0] p;
      p                         = '0;
      p[HEAD_DEST_LSB +: DAw]   = dest;
      p[HEAD_SRC_LSB +: DAw]    = src;
      p[HEAD_SIZE_LSB +: PLw]   = size;
      return p;
   endfunction

endpackage

// File: rtl/endp_vc_credit_ctr.sv
// Per-VC credit counter mirroring free slots in the router input buffer.
module endp_vc_credit_ctr #(
   parameter  int unsigned B  = 4,
   localparam int unsigned Cw = $clog2(B + 1)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          inc,
   input  logic          dec,
   output logic [Cw-1:0] avail,
   output logic          overflow
);

   // Count down on send, up on return; a return while full saturates and latches overflow.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         avail    <= Cw'(B);
         overflow <= 1'b0;
      end else if (inc && !dec) begin
         if (avail == Cw'(B)) overflow <= 1'b1;
         else                 avail    <= avail + Cw'(1);
      end else if (dec && !inc && (avail != '0)) begin
         avail <= avail - Cw'(1);
      end
   end

endmodule

// File: rtl/endp_packet_injector.sv
// Endpoint packet source: turns (dest, size) requests plus payload words into
// head/body/tail flits on a round-robin VC under credit-based flow control.
module endp_packet_injector
   import endp_packet_injector_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic [DAw-1:0]   current_addr,
   input  logic             pck_req_valid,
   output logic             pck_req_ready,
   input  logic [DAw-1:0]   pck_dest,
   input  logic [PLw-1:0]   pck_size,
   input  logic [Fpay-1:0]  data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic [Fw-1:0]    flit_out,
   output logic             flit_out_wr,
   input  logic [V-1:0]     credit_in,
   output logic             busy,
   output logic             err_size,
   output logic             err_credit
);

   logic [V-1:0][Cw-1:0] credit;
   logic [V-1:0]         has_credit;
   logic [V-1:0]         cred_dec;
   logic [V-1:0]         overflow;
   logic [V-1:0]         vc_oh;
   inj_state_e           state;
   logic [VW-1:0]        rr;
   logic [VW-1:0]        vc;
   logic [VW-1:0]        sel;
   logic                 sel_found;
   logic [PLw-1:0]       size_q;
   logic [PLw-1:0]       remaining;
   logic [DAw-1:0]       dest_q;
   logic                 accept;
   logic                 size_ok;
   logic                 emit_head;
   logic                 body_hs;

   // One credit counter per VC; only the packet's VC is ever debited.
   for (genvar g = 0; g < V; g++) begin : g_vc
      endp_vc_credit_ctr #(.B(B)) u_ctr (
         .clk      (clk),
         .reset    (reset),
         .inc      (credit_in[g]),
         .dec      (cred_dec[g]),
         .avail    (credit[g]),
         .overflow (overflow[g])
      );
      assign has_credit[g] = (credit[g] != '0);
   end

   assign pck_req_ready = (state == IDLE) && (|has_credit);
   assign data_ready    = (state == BODY) && has_credit[vc];
   assign busy          = (state != IDLE);
   assign err_credit    = |overflow;

   assign accept    = pck_req_valid && pck_req_ready;
   assign size_ok   = (pck_size != '0) && (pck_size <= PLw'(MAX_PCK_SIZ));
   assign emit_head = (state == HEAD) && has_credit[vc];
   assign body_hs   = data_ready && data_valid;
   assign vc_oh     = V'(1) << vc;
   assign cred_dec  = (emit_head || body_hs) ? vc_oh : '0;

   // Round-robin pick: first VC holding credit at or after the rr pointer.
   always_comb begin
      sel       = rr;
      sel_found = 1'b0;
      for (int unsigned i = 0; i < V; i++) begin
         if (!sel_found && has_credit[VW'((32'(rr) + i) % V)]) begin
            sel       = VW'((32'(rr) + i) % V);
            sel_found = 1'b1;
         end
      end
   end

   // Packet FSM with registered flit output; VC is frozen for the whole packet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         rr          <= '0;
         vc          <= '0;
         dest_q      <= '0;
         size_q      <= '0;
         remaining   <= '0;
         flit_out    <= '0;
         flit_out_wr <= 1'b0;
         err_size    <= 1'b0;
      end else begin
         flit_out_wr <= 1'b0;
         err_size    <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (!size_ok) begin
                     err_size <= 1'b1;
                  end else begin
                     dest_q <= pck_dest;
                     size_q <= pck_size;
                     vc     <= sel;
                     rr     <= VW'((32'(sel) + 32'd1) % V);
                     state  <= HEAD;
                  end
               end
            end
            HEAD: begin
               if (emit_head) begin
                  flit_out_wr <= 1'b1;
                  flit_out    <= pack_flit(1'b1, size_q == PLw'(1), vc_oh,
                                           head_payload(size_q, current_addr, dest_q));
                  remaining   <= size_q - PLw'(1);
                  state       <= (size_q == PLw'(1)) ? IDLE : BODY;
               end
            end
            BODY: begin
               if (body_hs) begin
                  flit_out_wr <= 1'b1;
                  flit_out    <= pack_flit(1'b0, remaining == PLw'(1), vc_oh, data_in);
                  remaining   <= remaining - PLw'(1);
                  if (remaining == PLw'(1)) state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_endp_packet_injector.sv
// Scoreboard bench for endp_packet_injector: a packet-level reference model
// predicts flits, handshake readiness and credit state; a monitor checks flits.
`timescale 1ns/1ps
module tb_endp_packet_injector;
   import endp_packet_injector_pkg::*;

   localparam int P_IDLE = 0;
   localparam int P_HEAD = 1;
   localparam int P_BODY = 2;

   logic             clk = 1'b0;
   logic             reset = 1'b1;
   logic [DAw-1:0]   current_addr;
   logic             pck_req_valid;
   logic             pck_req_ready;
   logic [DAw-1:0]   pck_dest;
   logic [PLw-1:0]   pck_size;
   logic [Fpay-1:0]  data_in;
   logic             data_valid;
   logic             data_ready;
   logic [Fw-1:0]    flit_out;
   logic             flit_out_wr;
   logic [V-1:0]     credit_in;
   logic             busy;
   logic             err_size;
   logic             err_credit;

   always #5 clk = ~clk;

   endp_packet_injector dut (
      .clk           (clk),
      .reset         (reset),
      .current_addr  (current_addr),
      .pck_req_valid (pck_req_valid),
      .pck_req_ready (pck_req_ready),
      .pck_dest      (pck_dest),
      .pck_size      (pck_size),
      .data_in       (data_in),
      .data_valid    (data_valid),
      .data_ready    (data_ready),
      .flit_out      (flit_out),
      .flit_out_wr   (flit_out_wr),
      .credit_in     (credit_in),
      .busy          (busy),
      .err_size      (err_size),
      .err_credit    (err_credit)
   );

   int            compared   = 0;
   int            mismatched = 0;
   logic [Fw-1:0] sb[$];
   logic [Fw-1:0] last_exp = '0;

   // reference model state
   int            mcred[V];
   int            mrr, mvc, mphase, mrem, msize;
   logic [7:0]    mdest;
   bit            m_err_size, m_err_credit, m_last_hs;
   logic [31:0]   cur_d;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // {hdr, tail, onehot vc, payload} built from plain arithmetic
   function automatic logic [Fw-1:0] exp_flit(input bit hdr, input bit tail, input int vcn,
                                              input logic [31:0] pay);
      logic [Fw-1:0] f;
      f = Fw'(pay);
      f = f | (Fw'(1) << (Fpay + vcn));
      if (tail) f = f | (Fw'(1) << (Fw - 2));
      if (hdr)  f = f | (Fw'(1) << (Fw - 1));
      return f;
   endfunction

   function automatic int pick_vc();
      for (int i = 0; i < int'(V); i++)
         if (mcred[(mrr + i) % int'(V)] > 0) return (mrr + i) % int'(V);
      return 0;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < int'(V); i++) mcred[i] = int'(B);
      mrr = 0; mvc = 0; mphase = P_IDLE; mrem = 0; msize = 0; mdest = '0;
      m_err_size = 0; m_err_credit = 0; m_last_hs = 0;
      sb.delete();
   endtask

   // One clock: drive inputs, check model-predicted status, advance the model over the edge.
   task automatic step(input bit rv, input logic [7:0] dst, input logic [PLw-1:0] sz,
                       input bit dv, input logic [31:0] d, input logic [V-1:0] cr);
      bit         exp_rdy, exp_drdy, any;
      bit [V-1:0] dec;
      @(negedge clk);
      pck_req_valid = rv; pck_dest = dst; pck_size = sz;
      data_valid = dv; data_in = d; credit_in = cr;
      #1;
      any = 0;
      for (int i = 0; i < int'(V); i++) if (mcred[i] > 0) any = 1;
      exp_rdy  = (mphase == P_IDLE) && any;
      exp_drdy = (mphase == P_BODY) && (mcred[mvc] > 0);
      chk("pck_req_ready", 64'(pck_req_ready), 64'(exp_rdy));
      chk("data_ready", 64'(data_ready), 64'(exp_drdy));
      chk("busy", 64'(busy), 64'(mphase != P_IDLE));
      chk("err_size", 64'(err_size), 64'(m_err_size));
      chk("err_credit", 64'(err_credit), 64'(m_err_credit));
      chk("credit0", 64'(dut.credit[0]), 64'(mcred[0]));
      chk("credit1", 64'(dut.credit[1]), 64'(mcred[1]));

      dec = '0; m_err_size = 0; m_last_hs = 0;
      case (mphase)
         P_HEAD: if (mcred[mvc] > 0) begin
            sb.push_back(exp_flit(1'b1, msize == 1, mvc,
                         (32'(msize) << 16) | (32'(current_addr) << 8) | 32'(mdest)));
            dec[mvc] = 1'b1;
            if (msize == 1) mphase = P_IDLE;
            else begin mphase = P_BODY; mrem = msize - 1; end
         end
         P_BODY: if (dv && exp_drdy) begin
            sb.push_back(exp_flit(1'b0, mrem == 1, mvc, d));
            dec[mvc] = 1'b1; m_last_hs = 1;
            mrem--;
            if (mrem == 0) mphase = P_IDLE;
         end
         default: if (rv && exp_rdy) begin
            if (sz == 0 || sz > MAX_PCK_SIZ) m_err_size = 1;
            else begin
               mvc = pick_vc(); mrr = (mvc + 1) % int'(V);
               msize = int'(sz); mdest = dst; mphase = P_HEAD;
            end
         end
      endcase
      for (int i = 0; i < int'(V); i++) begin
         if (cr[i] && !dec[i]) begin
            if (mcred[i] == int'(B)) m_err_credit = 1;
            else mcred[i]++;
         end else if (dec[i] && !cr[i]) mcred[i]--;
      end
   endtask

   task automatic idle();
      step(0, 8'h0, '0, 0, 32'h0, '0);
   endtask

   task automatic body_step(input logic [V-1:0] cr);
      step(0, 8'h0, '0, 1, cur_d, cr);
      if (m_last_hs) cur_d++;
   endtask

   task automatic do_reset();
      @(negedge clk); #2;
      reset = 1'b1; pck_req_valid = 0; data_valid = 0; credit_in = '0;
      #1;
      chk("rst_flit_out_wr", 64'(flit_out_wr), 64'(0));
      chk("rst_flit_out", 64'(flit_out), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_err_size", 64'(err_size), 64'(0));
      chk("rst_err_credit", 64'(err_credit), 64'(0));
      model_reset();
      @(negedge clk); #2;
      reset = 1'b0;
   endtask

   // Request a packet, then feed payload words until the model says the tail went out.
   task automatic run_pkt(input logic [7:0] dst, input logic [PLw-1:0] sz,
                          input logic [31:0] d0, input int budget);
      int n = 0;
      cur_d = d0;
      do begin step(1, dst, sz, 0, 32'h0, '0); n++; end
      while (mphase == P_IDLE && !m_err_size && n < budget);
      while (mphase != P_IDLE && n < budget) begin body_step('0); n++; end
      if (mphase != P_IDLE || n >= budget) begin
         compared++; mismatched++;
         $display("FAIL pkt_timeout: got model phase %0d after %0d cycles, expected idle", mphase, n);
      end
   endtask

   // Scoreboard monitor: every written flit must match the oldest prediction; otherwise flit_out holds.
   always @(negedge clk) begin
      if (reset) last_exp = '0;
      else if (flit_out_wr) begin
         if (sb.size() == 0) begin
            compared++; mismatched++;
            $display("FAIL flit_out: got 0x%0h, expected no flit", flit_out);
         end else begin
            last_exp = sb.pop_front();
            chk("flit_out", 64'(flit_out), 64'(last_exp));
         end
      end else chk("flit_hold", 64'(flit_out), 64'(last_exp));
   end

   initial begin
      current_addr = 8'h3C;
      pck_req_valid = 0; pck_dest = '0; pck_size = '0;
      data_in = '0; data_valid = 0; credit_in = '0;
      model_reset();
      do_reset();

      // single-flit packet
      step(1, 8'd5, PLw'(1), 0, 32'h0, '0);
      repeat (3) idle();

      // 4-flit packet on vc0, then next packet rotates to vc1
      do_reset();
      run_pkt(8'h21, PLw'(4), 32'hA, 40);
      run_pkt(8'h22, PLw'(2), 32'h100, 40);
      repeat (2) idle();

      // no credit return: stall after B flits, then one flit per returned credit
      do_reset();
      step(1, 8'h33, PLw'(6), 0, 32'h0, '0);
      cur_d = 32'h50;
      repeat (8) body_step('0);
      for (int k = 0; k < 2; k++) begin
         body_step(V'(1) << mvc);
         body_step('0);
         body_step('0);
      end
      repeat (2) idle();

      // bad sizes are consumed with an error pulse and no flits
      do_reset();
      step(1, 8'h07, PLw'(0), 0, 32'h0, '0);
      idle();
      step(1, 8'h07, PLw'(17), 0, 32'h0, '0);
      repeat (2) idle();

      // simultaneous send + return keeps the count; extra return at full latches err_credit
      do_reset();
      step(1, 8'h09, PLw'(3), 0, 32'h0, '0);
      cur_d = 32'h77;
      repeat (3) body_step(V'(1));
      step(0, 8'h0, '0, 0, 32'h0, V'(1));
      repeat (3) idle();

      // reset in the middle of a body
      do_reset();
      step(1, 8'h44, PLw'(8), 0, 32'h0, '0);
      cur_d = 32'h900;
      repeat (3) body_step('0);
      do_reset();
      repeat (2) idle();

      // randomized traffic
      do_reset();
      for (int c = 0; c < 2000; c++) begin
         bit             rv, dv;
         logic [PLw-1:0] sz;
         logic [V-1:0]   cr;
         int             r;
         rv = ($urandom % 3) == 0;
         r  = int'($urandom % 10);
         if (r == 0) sz = ($urandom % 2) ? PLw'(0) : PLw'(17 + ($urandom % 15));
         else        sz = PLw'(1 + ($urandom % 16));
         dv = ($urandom % 4) != 0;
         for (int i = 0; i < int'(V); i++)
            cr[i] = (($urandom % 3) == 0) && (mcred[i] < int'(B));
         step(rv, 8'($urandom), sz, dv, $urandom, cr);
      end
      // drain with full data and credit supply
      for (int c = 0; c < 60; c++) begin
         logic [V-1:0] cr;
         for (int i = 0; i < int'(V); i++) cr[i] = (mcred[i] < int'(B));
         step(0, 8'h0, '0, 1, $urandom, cr);
      end
      repeat (3) idle();
      chk("sb_empty", 64'(sb.size()), 64'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
